// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI slave endpoint: default frame width,
// bit counter width and the frame state encoding.
package spi_pkg;

  localparam int SPI_DATA_W = 16;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Bundle of the SPI pins and the local TX/RX handshake of the slave endpoint.
// The slave modport is the endpoint's view; master is the view of whatever drives it.
interface spi_slave_rx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic              cs_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              overrun;
  logic              rx_ack;
  logic              busy;
  logic [SPI_CNT_W-1:0] bit_count;

  modport slave (
    input  cs_n, sclk, mosi, tx_data, tx_load, rx_ack,
    output miso, tx_ready, rx_data, rx_valid, overrun, busy, bit_count
  );

  modport master (
    output cs_n, sclk, mosi, tx_data, tx_load, rx_ack,
    input  miso, tx_ready, rx_data, rx_valid, overrun, busy, bit_count
  );

endinterface

// File: rtl/spi_slave_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by one extra
// register so rising and falling edges of the synchronised level can be detected.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave endpoint: oversamples cs_n/sclk/mosi, receives MSB-first MOSI words
// and returns a locally loaded word on MISO LSB-first.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_slave_rx_if.slave  bus
);

  logic cs_sync, cs_rise, cs_fall;
  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .async_i(bus.cs_n),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(bus.sclk),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(bus.mosi),
    .sync_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e               state_q;
  logic [DATA_W-1:0]    rx_shift_q;
  logic [DATA_W-1:0]    tx_shift_q;
  logic [DATA_W-1:0]    shadow_q;
  logic [DATA_W-1:0]    rx_data_q;
  logic [SPI_CNT_W-1:0] bit_count_q;
  logic                 miso_q;
  logic                 tx_ready_q;
  logic                 rx_valid_q;
  logic                 overrun_q;
  logic                 busy_q;
  logic                 unacked_q;

  logic                 transfer_d;
  logic [DATA_W-1:0]    tx_next_d;

  // A frame start (from IDLE or back-to-back from DONE) moves the shadow into tx_shift.
  always_comb begin
    transfer_d = 1'b0;
    if ((state_q == IDLE) && cs_fall) begin
      transfer_d = 1'b1;
    end
    if ((state_q == DONE) && !cs_sync) begin
      transfer_d = 1'b1;
    end
    tx_next_d = tx_ready_q ? '0 : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      shadow_q    <= '0;
      rx_data_q   <= '0;
      bit_count_q <= '0;
      miso_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      unacked_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;

      // A fresh rx_valid wins over a simultaneous ack, which only retires the older word.
      if (rx_valid_q) begin
        unacked_q <= 1'b1;
      end else if (bus.rx_ack) begin
        unacked_q <= 1'b0;
      end

      if (bus.tx_load && (tx_ready_q || transfer_d)) begin
        shadow_q   <= bus.tx_data;
        tx_ready_q <= 1'b0;
      end else if (transfer_d) begin
        tx_ready_q <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          miso_q <= tx_shift_q[0];
          if (cs_fall) begin
            tx_shift_q  <= tx_next_d;
            miso_q      <= tx_next_d[0];
            bit_count_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            bit_count_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            if (sclk_rise) begin
              rx_shift_q  <= {rx_shift_q[DATA_W-2:0], mosi_sync};
              bit_count_q <= bit_count_q + SPI_CNT_W'(1);
              if (bit_count_q == SPI_CNT_W'(DATA_W - 1)) begin
                state_q <= DONE;
              end
            end
            // With no bit taken yet, a falling edge is the tail of the previous frame.
            if (sclk_fall && (bit_count_q != '0)) begin
              tx_shift_q <= {1'b0, tx_shift_q[DATA_W-1:1]};
              miso_q     <= tx_shift_q[1];
            end
          end
        end

        DONE: begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
          if (unacked_q && !bus.rx_ack) begin
            overrun_q <= 1'b1;
          end
          if (!cs_sync) begin
            tx_shift_q  <= tx_next_d;
            miso_q      <= tx_next_d[0];
            bit_count_q <= '0;
            state_q     <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso      = miso_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;
  assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a bit-banged SPI master with a queue-based RX scoreboard
// and a word-level model of the TX shadow, ack flag and sticky overrun.
module tb_spi_slave_rx;

  localparam int HALF = 8;

  typedef struct {
    logic [15:0] data;
    logic        ovr;
  } rxExp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  spi_slave_rx_if bus ();

  spi_slave_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  rxExp_t expQ[$];
  logic        modelShadowFull = 1'b0;
  logic [15:0] modelShadow = '0;
  logic        modelUnacked = 1'b0;
  logic        modelOverrun = 1'b0;
  logic [15:0] lastRx = '0;
  logic        seen16 = 1'b0;
  logic        csLow = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every rx_valid pulse must match the oldest queued full frame.
  always @(negedge clk) begin
    rxExp_t e;
    if (bus.bit_count == 5'd16) seen16 = 1'b1;
    if (bus.rx_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("rx_data", bus.rx_data, e.data);
        checkOutput("overrun_at_valid", bus.overrun, e.ovr);
        checkOutput("bit_count_reached_16", seen16, 1);
      end
      seen16 = 1'b0;
    end
  end

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadTx(input logic [15:0] word);
    @(negedge clk);
    bus.tx_data = word;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
    if (!modelShadowFull) begin
      modelShadow = word;
      modelShadowFull = 1'b1;
    end
    waitClks(2);
    checkOutput("tx_ready_after_load", bus.tx_ready, !modelShadowFull);
  endtask

  task automatic ackRx();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    modelUnacked = 1'b0;
  endtask

  // One master frame of nbits sclk pulses; full frames are queued and the MISO word checked.
  task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit endCs);
    logic [15:0] cap;
    logic [15:0] expMiso;
    rxExp_t e;
    cap = '0;
    expMiso = modelShadowFull ? modelShadow : 16'h0000;
    modelShadowFull = 1'b0;
    if (nbits == 16) begin
      modelOverrun = modelOverrun | modelUnacked;
      modelUnacked = 1'b1;
      e.data = word;
      e.ovr = modelOverrun;
      expQ.push_back(e);
      lastRx = word;
    end
    if (!csLow) begin
      @(negedge clk);
      bus.cs_n = 1'b0;
      csLow = 1'b1;
    end
    waitClks(HALF);
    checkOutput("tx_ready_frame_start", bus.tx_ready, 1);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = word[15-i];
      waitClks(HALF);
      bus.sclk = 1'b1;
      cap = {bus.miso, cap[15:1]};
      waitClks(HALF);
      bus.sclk = 1'b0;
    end
    waitClks(HALF);
    if (nbits == 16) checkOutput("miso_word", cap, expMiso);
    if (endCs) begin
      bus.cs_n = 1'b1;
      csLow = 1'b0;
      waitClks(2 * HALF);
      checkOutput("busy_after_cs_high", bus.busy, 0);
      checkOutput("bit_count_after_cs_high", bus.bit_count, 0);
      checkOutput("rx_data_held", bus.rx_data, lastRx);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("reset_miso", bus.miso, 0);
    checkOutput("reset_tx_ready", bus.tx_ready, 1);
    checkOutput("reset_rx_data", bus.rx_data, 0);
    checkOutput("reset_rx_valid", bus.rx_valid, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_bit_count", bus.bit_count, 0);
  endtask

  task automatic modelReset();
    modelShadowFull = 1'b0;
    modelUnacked = 1'b0;
    modelOverrun = 1'b0;
    lastRx = '0;
    seen16 = 1'b0;
    expQ.delete();
  endtask

  initial begin
    logic [15:0] w;
    int nb;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    bus.rx_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    @(negedge clk);
    reset = 1'b0;
    waitClks(4);

    $display("[TB] receive 16'hA5C3");
    applyStimulus(16'hA5C3, 16, 1'b1);
    ackRx();

    $display("[TB] transmit 16'h1234");
    loadTx(16'h1234);
    applyStimulus(16'h5A5A, 16, 1'b1);
    ackRx();

    $display("[TB] abort after 7 bits, then 16'h00FF");
    applyStimulus(16'hFFFF, 7, 1'b1);
    applyStimulus(16'h00FF, 16, 1'b1);
    ackRx();

    $display("[TB] back-to-back without ack");
    applyStimulus(16'h1111, 16, 1'b0);
    applyStimulus(16'h2222, 16, 1'b1);
    checkOutput("overrun_sticky", bus.overrun, 1);
    ackRx();
    waitClks(4);
    checkOutput("overrun_after_ack", bus.overrun, 1);

    $display("[TB] tx_load while shadow full");
    loadTx(16'hBEEF);
    loadTx(16'hDEAD);
    applyStimulus(16'h0F0F, 16, 1'b1);
    ackRx();

    $display("[TB] randomized frames");
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 1) == 1) loadTx(16'($urandom));
      if ($urandom_range(0, 2) == 0) loadTx(16'($urandom));
      w = 16'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
      if (nb == 16 && $urandom_range(0, 3) == 0) begin
        applyStimulus(w, 16, 1'b0);
        applyStimulus(16'($urandom), 16, 1'b1);
      end else begin
        applyStimulus(w, nb, 1'b1);
      end
      if ($urandom_range(0, 2) != 0) ackRx();
    end
    checkOutput("overrun_end_random", bus.overrun, modelOverrun);

    $display("[TB] reset after 9 bits");
    loadTx(16'hC0DE);
    applyStimulus(16'h9999, 9, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    csLow = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkResetValues();
    waitClks(2);
    reset = 1'b0;
    waitClks(4);

    applyStimulus(16'h3C5A, 16, 1'b1);

    for (int t = 0; t < 200 && expQ.size() != 0; t++) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Single-chip-select SPI slave endpoint; sits directly downstream of the SPI master, on one of its cs lines (cs_1 or cs_2).
- Oversamples the master's sclk, cs and MOSI with the local system clock.
- Deserialises 16-bit MSB-first MOSI frames into a parallel word with a valid strobe.
- Serialises a locally loaded 16-bit response word onto MISO, LSB-first, so the master's right-shift capture reassembles it in order.

Parameters:
- DATA_W, 16, frame width in bits; MOSI and MISO words are both this width.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on cs_n, sclk and mosi (min 2).

Ports:
- clk  input  1  system clock; must be at least 4x the sclk frequency.
- reset  input  1  synchronous, active-high reset.
- cs_n  input  1  chip select from master, active low.
- sclk  input  1  SPI clock from master, idle low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- tx_data  input  DATA_W  response word to shift out on MISO.
- tx_load  input  1  one-cycle strobe; captures tx_data into the TX shadow register.
- tx_ready  output  1  high when the shadow register is empty and may be loaded.
- rx_data  output  DATA_W  last complete MOSI word; held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- overrun  output  1  sticky flag: a frame completed while the previous rx_valid went unacknowledged; cleared only by reset.
- rx_ack  input  1  consumer acknowledges rx_data.
- busy  output  1  high while a frame is in progress.
- bit_count  output  5  number of MOSI bits received in the current frame, 0..DATA_W.

Behaviour:
- Reset values:
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0, bit_count=0.
  - Shift registers cleared; state=IDLE.
  - Synchronisers preset to cs_n=1, sclk=0.
- Input conditioning:
  - cs_n, sclk and mosi pass through SYNC_STAGES flops.
  - One further register on the synchronised sclk gives rise and fall detection.
  - All decisions use synchronised signals, so the latency from a pin edge to its effect is SYNC_STAGES+1 clk cycles.
- State machine: IDLE, SHIFT, DONE.
  - IDLE:
    - miso driven with tx_shift[0]; busy=0.
    - On synchronised cs_n falling: copy the shadow register into tx_shift, or 0 if the shadow is empty.
    - In the same transition: set tx_ready=1, bit_count=0, go to SHIFT.
  - SHIFT, on sclk rising:
    - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
    - bit_count increments.
  - SHIFT, on sclk falling:
    - tx_shift shifts right by 1; miso <= the new bit 0.
  - SHIFT, when bit_count reaches DATA_W: go to DONE.
  - DONE (one cycle):
    - rx_data <= rx_shift; rx_valid=1.
    - If an earlier rx_valid has not been acked, overrun <= 1.
    - Then go to SHIFT if cs_n is still low (back-to-back frame, bit_count=0, reload tx_shift from the shadow); otherwise go to IDLE.
- cs_n rising while in SHIFT with bit_count<DATA_W:
  - Abort the frame: no rx_valid, rx_data unchanged, bit_count=0, go to IDLE.
- sclk edges while cs_n is high are ignored.
- TX handshake:
  - tx_load while tx_ready=1 captures tx_data and sets tx_ready=0.
  - tx_load while tx_ready=0 is ignored and the shadow is unchanged.
  - tx_load in the same cycle as a shadow-to-tx_shift transfer: the transfer takes the old shadow, then the new word is captured.
- RX handshake:
  - An unacked flag is set by rx_valid and cleared by rx_ack.
  - rx_ack in the same cycle as rx_valid clears the flag for the previous word only; the new word remains unacked.
- Reset asserted mid-frame returns the block to its reset state on the next clk edge, overriding all other events.

Decomposition:
- Shared package spi_pkg holds:
  - DATA_W default;
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the bit counter width.
- Sub-module spi_sync_edge: a parametrised synchroniser plus rise/fall detector, instantiated three times (cs_n, sclk, mosi; edges unused for mosi).

Test Plan:
- MOSI receive: reset, then a master frame sending 16'hA5C3 MSB-first -> rx_valid pulses once, rx_data=16'hA5C3, bit_count reached 16, busy falls after cs_n rises.
- MISO transmit: tx_load with tx_data=16'h1234 before cs_n falls, then a full frame -> the master's captured word is 16'h1234 (LSB-first), and tx_ready=1 from frame start.
- Abort: cs_n raised after 7 sclk rising edges -> no rx_valid, rx_data keeps its prior value, bit_count=0; the next full frame of 16'h00FF is received correctly.
- Overrun: two back-to-back frames (16'h1111, then 16'h2222) with no rx_ack -> overrun=1 after the second, rx_data=16'h2222; overrun stays set until reset.
- TX handshake: tx_load of 16'hBEEF, then tx_load of 16'hDEAD while tx_ready=0 -> the frame shifts out 16'hBEEF.
- Reset mid-frame: reset asserted after 9 bits -> all outputs at reset values next cycle; no rx_valid.
